qdr_dly_stepper: RTL and testbench
==================================

Name: qdr_dly_stepper

Overview:
- OPB-attached controller for N input/output delay-tap channels on the QDR interface.
- Adds what the plain delay-enable register block lacks:
  - programmable multi-step bursts, with a settling gap between steps;
  - a per-channel tap counter that saturates at 0 and at the maximum tap;
  - indexed readback of each channel's tap value.
- Sits between the OPB bus and the QDR PHY delay elements, in a single clock domain. The delay elements are clocked by OPB_Clk.

Parameters:
C_BASEADDR, 0, OPB base address of register window
C_HIGHADDR, 0, OPB high address (exclusive bound for decode)
C_OPB_AWIDTH, 32, OPB address width
C_OPB_DWIDTH, 32, OPB data width
NUM_CH, 73, number of delay channels (1..128)
TAP_W, 5, tap counter width; maximum tap = 2^TAP_W-1
GAP, 4, idle cycles between consecutive enable pulses (>=1)

Ports:
OPB_Clk  in  1  sole clock
OPB_Rst_n  in  1  asynchronous, active-low reset
OPB_ABus  in  32  OPB address
OPB_BE  in  4  byte enables (ignored; full-word access only)
OPB_DBus  in  32  write data, bit [0:31] ordering; field bit n below = OPB_DBus[31-n]
OPB_RNW  in  1  1=read
OPB_select  in  1  OPB select
OPB_seqAddr  in  1  unused
Sl_DBus  out  32  read data, zero when not acking
Sl_xferAck  out  1  transfer acknowledge
Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  tied 0
dly_en  out  NUM_CH  one-cycle per-channel delay enable pulses
dly_inc_dec  out  1  direction: 1=increment, 0=decrement
dly_busy  out  1  high while a burst is in progress

Behaviour:
- Decode:
  - sel = OPB_select && C_BASEADDR <= OPB_ABus < C_HIGHADDR.
  - Word index = (OPB_ABus-C_BASEADDR)[5:2].
- Bus handshake:
  - Sl_xferAck rises the cycle after sel, when it was low; it lasts exactly one cycle.
  - A continuously held select acks every other cycle.
  - Writes take effect on the ack cycle edge.
- Register map:
  - 0 CTRL (W):
    - bit0 start; bit1 dir; bit2 abort; bit3 clear_taps; bits[12:8] steps.
    - Read returns dir and steps last written.
  - 1 STATUS (R):
    - bit0 busy; bit1 done (sticky); bit2 aborted (sticky); bit3 sat (sticky); bits[12:8] steps remaining.
    - Sticky bits clear on any CTRL write.
  - 2 MASK_IDX (R/W): bits[1:0] select the mask word.
  - 3 MASK_DATA (R/W):
    - Mask word k covers channels 32k..32k+31.
    - Bits at or above NUM_CH read 0.
  - 4 TAP_IDX (R/W): bits[6:0] select a channel.
  - 5 TAP_VAL (R):
    - bits[TAP_W-1:0] = tap count of the selected channel.
    - Reads 0 if index >= NUM_CH.
  - Other indices: read 0, writes ignored.
- Reset values:
  - All outputs 0.
  - Masks, taps, steps, sticky bits and idx registers all 0.
  - FSM in IDLE.
- FSM states: IDLE, PULSE, GAP, DONE.
  - IDLE:
    - A CTRL write with start=1 and steps>0 latches mask into act_mask, dir into dly_inc_dec, and steps into remaining; then → PULSE.
    - steps=0 with start → done=1 and stays in IDLE.
  - PULSE (1 cycle):
    - dly_en = act_mask & ~at_bound.
    - at_bound = tap==max when incrementing, tap==0 when decrementing.
    - Enabled channels' taps change by ±1.
    - If any masked channel is at its bound, sat=1.
    - remaining decrements → GAP.
  - GAP:
    - Counts GAP cycles.
    - Then → PULSE if remaining>0, else → DONE.
  - DONE (1 cycle): sets done=1 → IDLE.
- dly_busy = state != IDLE. dly_inc_dec is held stable through the whole burst.
- Start while busy: ignored; no sticky bit is set.
- Abort (CTRL bit2) while busy:
  - Next state IDLE; aborted=1; done stays 0.
  - A pulse in the same cycle still completes.
- clear_taps:
  - Honoured only in IDLE; ignored when busy.
  - Zeroes all tap counters.
  - Emits no pulses.
- Mask writes during a burst update the mask registers only; act_mask is unchanged.
- Asynchronous reset mid-burst: immediate return to IDLE; dly_en=0 in the same instant.

Decomposition:
- Package qdr_dly_pkg holds:
  - register index constants (REG_CTRL..REG_TAP_VAL);
  - CTRL/STATUS field bit positions;
  - the FSM state enum.
- Sub-module qdr_dly_tap_cntr: a single-channel saturating up/down counter.
  - Inputs: en, dir, clr.
  - Outputs: tap, at_max, at_min.
  - Generated NUM_CH times.

Test Plan:
- Reset, then read all registers → STATUS=0, TAP_VAL=0 for channels 0, 40 and 72; dly_en=0.
- MASK word0=0x0000_0005, CTRL start dir=1 steps=3 →
  - three 1-cycle pulses on dly_en[0] and dly_en[2], GAP+1=5 cycles apart;
  - busy for 3 pulse + 3 gap + 1 done cycles;
  - TAP_VAL(ch0)=3, TAP_VAL(ch2)=3, done=1.
- Channel 72 (word2 bit8) with taps at 30, inc steps=5 → exactly 1 pulse on dly_en[72]; tap=31; sat=1; done=1.
- Start dir=0 steps=31 on channel 1, abort written after the 2nd pulse → tap=0 (saturated at 0, so no pulses); aborted=1; done=0; busy low within 1 cycle of the abort ack.
- Start with steps=0 → no pulses; done=1. Second start issued while busy → ignored; remaining unchanged.
- Assert OPB_Rst_n low in the middle of a GAP state → dly_en and dly_busy drop to 0 asynchronously; all taps read 0 after release.

Source files
------------

// File: rtl/qdr_dly_pkg.sv
// Shared definitions for the QDR delay-tap stepper: register word indices,
// CTRL/STATUS field positions (in little-endian field numbering, i.e. after
// the OPB bit-order swap) and the burst FSM state encoding.
package qdr_dly_pkg;

    localparam logic [3:0] REG_CTRL      = 4'd0;
    localparam logic [3:0] REG_STATUS    = 4'd1;
    localparam logic [3:0] REG_MASK_IDX  = 4'd2;
    localparam logic [3:0] REG_MASK_DATA = 4'd3;
    localparam logic [3:0] REG_TAP_IDX   = 4'd4;
    localparam logic [3:0] REG_TAP_VAL   = 4'd5;

    localparam int unsigned CTRL_START = 0;
    localparam int unsigned CTRL_DIR   = 1;
    localparam int unsigned CTRL_ABORT = 2;
    localparam int unsigned CTRL_CLEAR = 3;
    localparam int unsigned STEPS_LSB  = 8;
    localparam int unsigned STEPS_W    = 5;

    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_DONE    = 1;
    localparam int unsigned STAT_ABORTED = 2;
    localparam int unsigned STAT_SAT     = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PULSE,
        S_GAP,
        S_DONE
    } dly_state_e;

endpackage

// File: rtl/qdr_dly_tap_cntr.sv
// Single-channel saturating up/down tap counter mirroring one PHY delay element.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : one-cycle step request (already gated against the bound)
//   dir        : 1 = increment, 0 = decrement
//   clr        : synchronous clear to tap 0 (wins over en)
//   tap        : current tap count
//   at_max     : tap is at 2^TAP_W-1
//   at_min     : tap is at 0
module qdr_dly_tap_cntr #(
    parameter int unsigned TAP_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             dir,
    input  logic             clr,
    output logic [TAP_W-1:0] tap,
    output logic             at_max,
    output logic             at_min
);

    assign at_max = (tap == '1);
    assign at_min = (tap == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap <= '0;
        end else if (clr) begin
            tap <= '0;
        end else if (en) begin
            if (dir && !at_max) begin
                tap <= tap + 1'b1;
            end else if (!dir && !at_min) begin
                tap <= tap - 1'b1;
            end
        end
    end

endmodule

// File: rtl/qdr_dly_stepper.sv
// OPB slave that issues programmable bursts of delay-enable pulses to NUM_CH
// QDR PHY delay taps, keeps a saturating shadow tap count per channel and
// offers indexed tap readback.
//   OPB_Clk, OPB_Rst_n          : clock, asynchronous active-low reset
//   OPB_ABus/DBus/RNW/select    : OPB slave request (DBus in [0:31] bit order)
//   OPB_BE, OPB_seqAddr         : unused
//   Sl_DBus, Sl_xferAck         : read data (0 when not acking), acknowledge
//   Sl_errAck/retry/toutSup     : tied 0
//   dly_en                      : one-cycle per-channel delay enable pulses
//   dly_inc_dec                 : burst direction, held for the whole burst
//   dly_busy                    : burst in progress
module qdr_dly_stepper
    import qdr_dly_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
    parameter logic [31:0] C_HIGHADDR   = 32'h0000_0000,
    parameter int unsigned C_OPB_AWIDTH = 32,
    parameter int unsigned C_OPB_DWIDTH = 32,
    parameter int unsigned NUM_CH       = 73,
    parameter int unsigned TAP_W        = 5,
    parameter int unsigned GAP          = 4
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst_n,
    input  logic [C_OPB_AWIDTH-1:0] OPB_ABus,
    input  logic [3:0]              OPB_BE,
    input  logic [C_OPB_DWIDTH-1:0] OPB_DBus,
    input  logic                    OPB_RNW,
    input  logic                    OPB_select,
    input  logic                    OPB_seqAddr,
    output logic [C_OPB_DWIDTH-1:0] Sl_DBus,
    output logic                    Sl_xferAck,
    output logic                    Sl_errAck,
    output logic                    Sl_retry,
    output logic                    Sl_toutSup,
    output logic [NUM_CH-1:0]       dly_en,
    output logic                    dly_inc_dec,
    output logic                    dly_busy
);

    localparam logic [C_OPB_AWIDTH-1:0] BASE = C_OPB_AWIDTH'(C_BASEADDR);
    localparam logic [C_OPB_AWIDTH-1:0] SPAN = C_OPB_AWIDTH'(C_HIGHADDR - C_BASEADDR);
    localparam logic [127:0] CH_VALID = (NUM_CH >= 128) ? '1 : ((128'd1 << NUM_CH) - 128'd1);
    localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

    logic [C_OPB_AWIDTH-1:0] offs;
    logic [C_OPB_AWIDTH:0]   span_diff;
    logic                    sel, wr, ctrl_wr;
    logic [3:0]              widx;
    logic [C_OPB_DWIDTH-1:0] wfield, rfield;

    logic                    ctrl_dir;
    logic [STEPS_W-1:0]      ctrl_steps, remaining;
    logic [1:0]              mask_idx;
    logic [6:0]              tap_idx;
    logic [127:0]            mask_q, mask_vis;
    logic [NUM_CH-1:0]       act_mask, at_max, at_min, at_bound;
    logic [TAP_W-1:0]        taps [NUM_CH];
    logic [TAP_W-1:0]        tap_rd;
    logic                    done_q, aborted_q, sat_q;
    logic [GW-1:0]           gap_cnt;

    dly_state_e state, state_n;
    logic latch_burst, dec_rem, set_done, set_abort, set_sat, tap_clr;

    // Range check as a borrow out of offs - SPAN: one subtractor, and no
    // constant comparison when the window starts at address 0.
    assign offs      = OPB_ABus - BASE;
    assign span_diff = {1'b0, offs} - {1'b0, SPAN};
    assign sel       = OPB_select && span_diff[C_OPB_AWIDTH];
    assign widx      = offs[5:2];

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) Sl_xferAck <= 1'b0;
        else            Sl_xferAck <= sel && !Sl_xferAck;
    end

    assign wr      = Sl_xferAck && sel && !OPB_RNW;
    assign ctrl_wr = wr && (widx == REG_CTRL);

    always_comb begin
        wfield  = '0;
        Sl_DBus = '0;
        for (int unsigned i = 0; i < C_OPB_DWIDTH; i++) begin
            wfield[i] = OPB_DBus[C_OPB_DWIDTH-1-i];
            if (Sl_xferAck) Sl_DBus[C_OPB_DWIDTH-1-i] = rfield[i];
        end
    end

    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            ctrl_dir   <= 1'b0;
            ctrl_steps <= '0;
            mask_idx   <= '0;
            tap_idx    <= '0;
            mask_q     <= '0;
        end else if (wr) begin
            case (widx)
                REG_CTRL: begin
                    ctrl_dir   <= wfield[CTRL_DIR];
                    ctrl_steps <= wfield[STEPS_LSB +: STEPS_W];
                end
                REG_MASK_IDX:  mask_idx <= wfield[1:0];
                REG_MASK_DATA: mask_q[{mask_idx, 5'b0} +: 32] <= wfield[31:0];
                REG_TAP_IDX:   tap_idx <= wfield[6:0];
                default: ;
            endcase
        end
    end

    assign mask_vis = mask_q & CH_VALID;

    always_comb begin
        tap_rd = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (32'(tap_idx) == i) tap_rd = taps[i];
        end
    end

    always_comb begin
        rfield = '0;
        case (widx)
            REG_CTRL: begin
                rfield[CTRL_DIR]            = ctrl_dir;
                rfield[STEPS_LSB +: STEPS_W] = ctrl_steps;
            end
            REG_STATUS: begin
                rfield[STAT_BUSY]            = dly_busy;
                rfield[STAT_DONE]            = done_q;
                rfield[STAT_ABORTED]         = aborted_q;
                rfield[STAT_SAT]             = sat_q;
                rfield[STEPS_LSB +: STEPS_W] = remaining;
            end
            REG_MASK_IDX:  rfield[1:0]       = mask_idx;
            REG_MASK_DATA: rfield[31:0]      = mask_vis[{mask_idx, 5'b0} +: 32];
            REG_TAP_IDX:   rfield[6:0]       = tap_idx;
            REG_TAP_VAL:   rfield[TAP_W-1:0] = tap_rd;
            default: ;
        endcase
    end

    assign at_bound = dly_inc_dec ? at_max : at_min;

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) state <= S_IDLE;
        else            state <= state_n;
    end

    always_comb begin
        state_n     = state;
        latch_burst = 1'b0;
        dec_rem     = 1'b0;
        set_done    = 1'b0;
        set_abort   = 1'b0;
        set_sat     = 1'b0;
        dly_en      = '0;
        case (state)
            S_IDLE: begin
                if (ctrl_wr && wfield[CTRL_START]) begin
                    if (wfield[STEPS_LSB +: STEPS_W] != '0) begin
                        latch_burst = 1'b1;
                        state_n     = S_PULSE;
                    end else begin
                        set_done = 1'b1;
                    end
                end
            end
            S_PULSE: begin
                dly_en  = act_mask & ~at_bound;
                set_sat = |(act_mask & at_bound);
                dec_rem = 1'b1;
                state_n = S_GAP;
            end
            S_GAP: begin
                if (gap_cnt == GW'(GAP - 1)) state_n = (remaining != '0) ? S_PULSE : S_DONE;
            end
            S_DONE: begin
                set_done = 1'b1;
                state_n  = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
        // Abort overrides any transition, including DONE's done flag; the
        // combinational pulse of the current cycle is left untouched.
        if (state != S_IDLE && ctrl_wr && wfield[CTRL_ABORT]) begin
            state_n   = S_IDLE;
            set_abort = 1'b1;
            set_done  = 1'b0;
        end
    end

    assign dly_busy = (state != S_IDLE);
    assign tap_clr  = ctrl_wr && wfield[CTRL_CLEAR] && (state == S_IDLE);

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            gap_cnt     <= '0;
            remaining   <= '0;
            act_mask    <= '0;
            dly_inc_dec <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            gap_cnt <= (state == S_GAP) ? gap_cnt + 1'b1 : '0;
            if (latch_burst) begin
                remaining   <= wfield[STEPS_LSB +: STEPS_W];
                act_mask    <= mask_q[NUM_CH-1:0];
                dly_inc_dec <= wfield[CTRL_DIR];
            end else if (dec_rem) begin
                remaining <= remaining - 1'b1;
            end
            // A CTRL write clears the sticky flags; an event in the same cycle wins.
            if (ctrl_wr) begin
                done_q    <= 1'b0;
                aborted_q <= 1'b0;
                sat_q     <= 1'b0;
            end
            if (set_done)  done_q    <= 1'b1;
            if (set_abort) aborted_q <= 1'b1;
            if (set_sat)   sat_q     <= 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        qdr_dly_tap_cntr #(.TAP_W(TAP_W)) u_tap (
            .clk    (OPB_Clk),
            .rst_n  (OPB_Rst_n),
            .en     (dly_en[g]),
            .dir    (dly_inc_dec),
            .clr    (tap_clr),
            .tap    (taps[g]),
            .at_max (at_max[g]),
            .at_min (at_min[g])
        );
    end

    logic unused_ok;
    assign unused_ok = ^{OPB_BE, OPB_seqAddr, wfield};

endmodule

// File: tb/tb_qdr_dly_stepper.sv
module tb_qdr_dly_stepper;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] HIGH = 32'h8000_0040;
    localparam int unsigned NCH  = 73;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [31:0]     abus = '0;
    logic [3:0]      be = 4'hF;
    logic [31:0]     dbus = '0;
    logic            rnw = 1'b1;
    logic            sel = 1'b0;
    logic            seq = 1'b0;
    logic [31:0]     sl_dbus;
    logic            ack, err_ack, retry, tout_sup;
    logic [NCH-1:0]  dly_en;
    logic            dly_inc_dec, dly_busy;

    qdr_dly_stepper #(
        .C_BASEADDR   (BASE),
        .C_HIGHADDR   (HIGH),
        .C_OPB_AWIDTH (32),
        .C_OPB_DWIDTH (32),
        .NUM_CH       (NCH),
        .TAP_W        (5),
        .GAP          (4)
    ) dut (
        .OPB_Clk     (clk),
        .OPB_Rst_n   (rst_n),
        .OPB_ABus    (abus),
        .OPB_BE      (be),
        .OPB_DBus    (dbus),
        .OPB_RNW     (rnw),
        .OPB_select  (sel),
        .OPB_seqAddr (seq),
        .Sl_DBus     (sl_dbus),
        .Sl_xferAck  (ack),
        .Sl_errAck   (err_ack),
        .Sl_retry    (retry),
        .Sl_toutSup  (tout_sup),
        .dly_en      (dly_en),
        .dly_inc_dec (dly_inc_dec),
        .dly_busy    (dly_busy)
    );

    always #5 clk = ~clk;

    int unsigned n_chk = 0;
    int unsigned n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    // Monitor: cycle counter, busy cycles, pulse counts and ch0 pulse times.
    int unsigned cyc = 0, busy_cyc = 0, en_total = 0;
    int unsigned ch0_n = 0, ch1_n = 0, ch72_n = 0;
    int unsigned ch0_at [16];
    always @(negedge clk) begin
        cyc      <= cyc + 1;
        busy_cyc <= busy_cyc + (dly_busy ? 1 : 0);
        en_total <= en_total + $countones(dly_en);
        if (dly_en[0]) begin
            if (ch0_n < 16) ch0_at[ch0_n] <= cyc;
            ch0_n <= ch0_n + 1;
        end
        if (dly_en[1])  ch1_n  <= ch1_n + 1;
        if (dly_en[72]) ch72_n <= ch72_n + 1;
    end

    task automatic wait_ack();
        int unsigned n = 0;
        @(negedge clk);
        while (!ack && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!ack) chk("ack_timeout", {31'b0, ack}, 32'd1);
    endtask

    task automatic opb_wr(input int unsigned idx, input logic [31:0] fld);
        @(negedge clk);
        abus = BASE + 32'(idx * 4);
        dbus = rev32(fld);
        rnw  = 1'b0;
        sel  = 1'b1;
        wait_ack();
        @(negedge clk);
        sel = 1'b0;
        rnw = 1'b1;
    endtask

    task automatic opb_rd(input int unsigned idx, output logic [31:0] fld);
        @(negedge clk);
        abus = BASE + 32'(idx * 4);
        rnw  = 1'b1;
        sel  = 1'b1;
        wait_ack();
        fld = rev32(sl_dbus);
        @(negedge clk);
        sel = 1'b0;
    endtask

    task automatic rd_tap(input int unsigned ch, output logic [31:0] v);
        opb_wr(4, ch);
        opb_rd(5, v);
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        while (dly_busy && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", {31'b0, dly_busy}, 32'd0);
    endtask

    initial begin
        logic [31:0] v;
        int unsigned b0, b_en, b_busy, b1, b72, acks;

        // ---------------- reset ----------------
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_dly_en", {31'b0, |dly_en}, 0);
        chk("rst_busy", {31'b0, dly_busy}, 0);
        chk("rst_dir", {31'b0, dly_inc_dec}, 0);
        chk("rst_ack", {31'b0, ack}, 0);
        chk("rst_dbus", sl_dbus, 0);
        rst_n = 1'b1;
        opb_rd(1, v); chk("rst_status", v, 0);
        opb_rd(0, v); chk("rst_ctrl", v, 0);
        rd_tap(0, v);  chk("rst_tap0", v, 0);
        rd_tap(40, v); chk("rst_tap40", v, 0);
        rd_tap(72, v); chk("rst_tap72", v, 0);

        // ---------------- handshake ----------------
        @(negedge clk);
        abus = BASE + 32'd4; rnw = 1'b1; sel = 1'b1;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ack) acks++;
            else chk("dbus_no_ack", sl_dbus, 0);
        end
        chk("held_sel_acks", acks, 2);
        abus = HIGH;
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ack) acks++;
        end
        chk("out_of_range_acks", acks, 0);
        sel = 1'b0;

        // ---------------- inc burst, ch0+ch2, steps=3 ----------------
        opb_wr(2, 0);
        opb_wr(3, 32'h0000_0005);
        opb_rd(3, v); chk("mask0_rb", v, 32'h5);
        b0 = ch0_n; b_en = en_total; b_busy = busy_cyc;
        opb_wr(0, 32'h0000_0303);
        chk("burst_busy", {31'b0, dly_busy}, 1);
        chk("burst_dir", {31'b0, dly_inc_dec}, 1);
        wait_idle();
        @(negedge clk);
        chk("b1_ch0_pulses", ch0_n - b0, 3);
        chk("b1_all_pulses", en_total - b_en, 6);
        chk("b1_gap01", ch0_at[b0+1] - ch0_at[b0], 5);
        chk("b1_gap12", ch0_at[b0+2] - ch0_at[b0+1], 5);
        chk("b1_busy_cycles", busy_cyc - b_busy, 16);
        opb_rd(1, v); chk("b1_status", v, 32'h2);
        rd_tap(0, v); chk("b1_tap0", v, 3);
        rd_tap(2, v); chk("b1_tap2", v, 3);
        rd_tap(1, v); chk("b1_tap1", v, 0);

        // ---------------- ch72 to 30, then saturate ----------------
        opb_wr(2, 0); opb_wr(3, 0);
        opb_wr(2, 2); opb_wr(3, 32'h0000_0100);
        opb_wr(0, 32'h0000_1E03);
        wait_idle();
        opb_rd(1, v); chk("ch72_to30_status", v, 32'h2);
        rd_tap(72, v); chk("ch72_tap30", v, 30);
        b72 = ch72_n; b_en = en_total;
        opb_wr(0, 32'h0000_0503);
        wait_idle();
        @(negedge clk);
        chk("sat_ch72_pulses", ch72_n - b72, 1);
        chk("sat_all_pulses", en_total - b_en, 1);
        rd_tap(72, v); chk("sat_tap72", v, 31);
        opb_rd(1, v); chk("sat_status", v, 32'h0000_000A);
        rd_tap(100, v); chk("tap_idx_oob", v, 0);
        opb_wr(2, 2); opb_wr(3, 32'hFFFF_FFFF);
        opb_rd(3, v); chk("mask2_rb_trunc", v, 32'h0000_01FF);
        opb_wr(2, 3);
        opb_rd(3, v); chk("mask3_rb", v, 0);

        // ---------------- dec on ch1 with abort ----------------
        opb_wr(2, 2); opb_wr(3, 0);
        opb_wr(2, 0); opb_wr(3, 32'h0000_0002);
        b1 = ch1_n; b_en = en_total;
        opb_wr(0, 32'h0000_1F01);
        repeat (6) @(negedge clk);
        opb_wr(0, 32'h0000_0004);
        chk("abort_busy_low", {31'b0, dly_busy}, 0);
        @(negedge clk);
        chk("abort_ch1_pulses", ch1_n - b1, 0);
        chk("abort_all_pulses", en_total - b_en, 0);
        opb_rd(1, v); chk("abort_status", v, 32'h0000_1D04);
        rd_tap(1, v); chk("abort_tap1", v, 0);

        // ---------------- steps=0 start ----------------
        b_en = en_total; b_busy = busy_cyc;
        opb_wr(0, 32'h0000_0001);
        repeat (5) @(negedge clk);
        chk("zero_busy_cycles", busy_cyc - b_busy, 0);
        chk("zero_pulses", en_total - b_en, 0);
        opb_rd(1, v); chk("zero_status", v, 32'h0000_1D02);

        // ---------------- start while busy ----------------
        opb_wr(3, 32'h0000_0001);
        b0 = ch0_n;
        opb_wr(0, 32'h0000_0203);
        opb_wr(0, 32'h0000_0901);
        opb_rd(1, v); chk("busy_restart_status", v, 32'h0000_0101);
        wait_idle();
        @(negedge clk);
        chk("busy_restart_pulses", ch0_n - b0, 2);
        chk("busy_restart_dir", {31'b0, dly_inc_dec}, 1);
        rd_tap(0, v); chk("busy_restart_tap0", v, 5);
        opb_rd(1, v); chk("busy_restart_done", v, 32'h2);
        opb_rd(0, v); chk("ctrl_rb", v, 32'h0000_0900);

        // ---------------- clear taps ----------------
        b_en = en_total;
        opb_wr(0, 32'h0000_0008);
        @(negedge clk);
        chk("clr_pulses", en_total - b_en, 0);
        rd_tap(72, v); chk("clr_tap72", v, 0);
        rd_tap(0, v);  chk("clr_tap0", v, 0);

        // ---------------- clear ignored while busy, reset mid-GAP ----------------
        opb_wr(0, 32'h0000_0303);
        opb_wr(0, 32'h0000_0008);
        opb_rd(5, v); chk("busy_clr_ignored", v, 1);
        chk("pre_rst_busy", {31'b0, dly_busy}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", {31'b0, dly_busy}, 0);
        chk("async_rst_en", {31'b0, |dly_en}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rd_tap(0, v);  chk("post_rst_tap0", v, 0);
        rd_tap(2, v);  chk("post_rst_tap2", v, 0);
        rd_tap(72, v); chk("post_rst_tap72", v, 0);
        opb_rd(1, v);  chk("post_rst_status", v, 0);
        opb_rd(3, v);  chk("post_rst_mask", v, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
